// File: rtl/signed_divider.sv
// Sequential signed restoring divider: one quotient bit per cycle, truncating toward zero.
// Define DIV_SATURATE_EN to saturate quotients on overflow and divide-by-zero instead of wrapping.
module signed_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quot,
    output logic [W-1:0] rem,
    output logic         ovf,
    output logic         dbz
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state;
    logic [W-1:0]   dq;
    logic [W-1:0]   dvs;
    logic [W-1:0]   r;
    logic [CW-1:0]  cnt;
    logic           sign_q;
    logic           sign_r;
    logic           ovf_c;
    logic           dbz_c;

    logic [W:0]     rem_shift;
    logic [W:0]     trial;
    logic [W-1:0]   r_next;
    logic [W-1:0]   q_next;
    logic [W-1:0]   quot_val;
    logic [W-1:0]   rem_val;
    logic [W-1:0]   a_abs;
    logic [W-1:0]   b_abs;
    logic           accept;

    // |a| and |b| are held unsigned, so the most negative operand still fits in W bits.
    always_comb begin
        a_abs = a[W-1] ? -a : a;
        b_abs = b[W-1] ? -b : b;
        accept = start && (state == IDLE || state == DONE);

        rem_shift = {r, dq[W-1]};
        trial     = rem_shift - {1'b0, dvs};
        if (!trial[W]) begin
            r_next = trial[W-1:0];
            q_next = {dq[W-2:0], 1'b1};
        end else begin
            r_next = rem_shift[W-1:0];
            q_next = {dq[W-2:0], 1'b0};
        end

        quot_val = sign_q ? -q_next : q_next;
        rem_val  = sign_r ? -r_next : r_next;
`ifdef DIV_SATURATE_EN
        if (dbz_c) begin
            quot_val = sign_r ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
            rem_val  = '0;
        end else if (ovf_c) begin
            quot_val = {1'b0, {(W-1){1'b1}}};
            rem_val  = '0;
        end
`else
        // A zero divisor already leaves |a| in the remainder; only the quotient needs forcing.
        if (dbz_c) begin
            quot_val = '1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            quot   <= '0;
            rem    <= '0;
            ovf    <= 1'b0;
            dbz    <= 1'b0;
            dq     <= '0;
            dvs    <= '0;
            r      <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            ovf_c  <= 1'b0;
            dbz_c  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state  <= CALC;
                busy   <= 1'b1;
                dq     <= a_abs;
                dvs    <= b_abs;
                r      <= '0;
                cnt    <= CW'(W);
                sign_q <= a[W-1] ^ b[W-1];
                sign_r <= a[W-1];
                ovf_c  <= (a == {1'b1, {(W-1){1'b0}}}) && (b == '1);
                dbz_c  <= (b == '0);
            end else begin
                case (state)
                    CALC: begin
                        r   <= r_next;
                        dq  <= q_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == CW'(1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            quot  <= quot_val;
                            rem   <= rem_val;
                            ovf   <= ovf_c;
                            dbz   <= dbz_c;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: directed handshake/corner cases plus random operands
// compared against a plain-arithmetic reference model (honours DIV_SATURATE_EN).
module tb_signed_divider;

    localparam int W    = 8;
    localparam int MINV = -(1 << (W - 1));
    localparam int MAXV = (1 << (W - 1)) - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         ovf;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    signed_divider #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .quot  (quot),
        .rem   (rem),
        .ovf   (ovf),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Division defined by the arithmetic rules: truncate toward zero, remainder follows the dividend.
    function automatic void refModel(input int av, input int bv,
                                     output int eq, output int er, output int eo, output int ed);
        eo = 0;
        ed = 0;
        if (bv == 0) begin
            ed = 1;
`ifdef DIV_SATURATE_EN
            eq = (av < 0) ? MINV : MAXV;
            er = 0;
`else
            eq = -1;
            er = av;
`endif
        end else if (av == MINV && bv == -1) begin
            eo = 1;
            er = 0;
`ifdef DIV_SATURATE_EN
            eq = MAXV;
`else
            eq = MINV;
`endif
        end else begin
            eq = av / bv;
            er = av % bv;
        end
    endfunction

    task automatic applyStimulus(input int av, input int bv, input bit hold);
        @(negedge clk);
        a = av[W-1:0];
        b = bv[W-1:0];
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Called on the first sample after the accepting edge; lat counts samples up to done.
    task automatic waitDone(output int lat, output int busyCycles);
        lat = 1;
        busyCycles = 0;
        while (!done && lat < 40) begin
            if (busy) busyCycles++;
            @(negedge clk);
            lat++;
        end
        checkOutput("done_seen", int'(done), 1);
        checkOutput("busy_done_excl", int'(busy), 0);
    endtask

    task automatic checkResult(input string tag, input int av, input int bv);
        int eq, er, eo, ed;
        refModel(av, bv, eq, er, eo, ed);
        checkOutput({tag, "_quot"}, int'($signed(quot)), eq);
        checkOutput({tag, "_rem"},  int'($signed(rem)),  er);
        checkOutput({tag, "_ovf"},  int'(ovf), eo);
        checkOutput({tag, "_dbz"},  int'(dbz), ed);
    endtask

    task automatic runOp(input string tag, input int av, input int bv);
        int lat, bc;
        applyStimulus(av, bv, 1'b0);
        waitDone(lat, bc);
        checkResult(tag, av, bv);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
        checkOutput({tag, "_quot"}, int'(quot), 0);
        checkOutput({tag, "_rem"},  int'(rem),  0);
        checkOutput({tag, "_ovf"},  int'(ovf),  0);
        checkOutput({tag, "_dbz"},  int'(dbz),  0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat, bc, doneCount, av, bv;
        int dirA[10] = '{7, -7, -5, -128, 100, -100, 0, 127, -128, 1};
        int dirB[10] = '{-2, 2, -3, -1, 0, 0, 5, -128, 1, 127};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checkCleared("reset");
        rst = 1'b0;

        applyStimulus(-30, 2, 1'b0);
        waitDone(lat, bc);
        checkOutput("lat_first", lat, 9);
        checkOutput("busy_cycles", bc, 8);
        checkResult("m30_2", -30, 2);
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);

        for (int i = 0; i < 10; i++) begin
            runOp($sformatf("dir%0d", i), dirA[i], dirB[i]);
        end

        // Start held high across the whole operation chains straight into a second one.
        applyStimulus(100, 7, 1'b1);
        waitDone(lat, bc);
        checkResult("hold", 100, 7);
        @(negedge clk);
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("hold_lat2", lat, 9);
        checkResult("hold2", 100, 7);

        applyStimulus(45, 4, 1'b0);
        a = 8'h9d;
        b = 8'h03;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat, bc);
        checkResult("frozen", 45, 4);

        runOp("b2b_first", 50, 6);
        a = 8'h80;
        b = 8'h02;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(lat, bc);
        checkOutput("b2b_lat", lat, 9);
        checkResult("b2b", -128, 2);

        applyStimulus(40, 3, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkCleared("rst_mid");
        doneCount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("rst_no_done", doneCount, 0);
        runOp("after_rst", 40, -3);

        @(negedge clk);
        a = 8'h05;
        b = 8'h01;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        checkOutput("rst_start_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("rst_start_busy2", int'(busy), 0);

        for (int i = 0; i < 300; i++) begin
            av = int'($urandom_range(0, 255)) - 128;
            bv = int'($urandom_range(0, 255)) - 128;
            case ($urandom_range(0, 15))
                0: bv = 0;
                1: begin av = MINV; bv = -1; end
                2: bv = int'($urandom_range(0, 6)) - 3;
                3: av = MINV;
                default: ;
            endcase
            runOp("rand", av, bv);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/signed_divider.md
# signed_divider

Sequential signed two's-complement divider for the matrix coprocessor datapath. It is the inverse companion of the combinational 8-bit multiplier, used for element-wise division and scaling. A restoring shift-subtract loop computes one quotient bit per cycle behind a start/busy/done handshake. Quotient truncates toward zero, and divide-by-zero and overflow are flagged.

## Interface
- W, 8, operand and result width in bits (two's complement)
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when accepting (state IDLE or DONE)
- a  in  W  signed dividend; captured on the accepted start
- b  in  W  signed divisor; captured on the accepted start
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse; results valid from this cycle
- quot  out  W  signed quotient; holds until the next done
- rem  out  W  signed remainder; holds until the next done
- ovf  out  1  quotient not representable (a = -2^(W-1), b = -1)
- dbz  out  1  divisor was zero

## Operation
- States: IDLE, CALC, DONE.
- IDLE → CALC on start. Capture |a| and |b| as W-bit unsigned values (|-128| = 128 fits). Capture sign_q = a[W-1]^b[W-1] and sign_r = a[W-1]. Flag ovf_c and dbz_c. Load counter = W and partial remainder = 0.
- CALC, each cycle:
  - Shift the remainder left, bringing in the dividend MSB.
  - Trial-subtract |b| at W+1 bits. If the result is non-negative, keep it and set quotient bit = 1.
  - Decrement the counter; go to DONE when it reaches 0.
- Entering DONE:
  - Register quot = sign_q ? -q : q, and rem = sign_r ? -r : r.
  - Register the ovf and dbz flags. Pulse done.
- DONE → CALC if start is high, giving back-to-back operation. Otherwise DONE → IDLE.
- Start while in CALC is ignored. Operands are not re-sampled.
- Sign rules:
  - The remainder takes the dividend's sign, and |rem| < |b|.
  - The identity a = quot*b + rem holds whenever ovf = 0 and dbz = 0.
- Overflow case (a = -2^(W-1), b = -1): ovf = 1, quot = -2^(W-1) (wrapped), rem = 0.
- Divide by zero: dbz = 1, ovf = 0, quot = all ones (-1), rem = a.
- Special cases use the full CALC loop; latency does not depend on the data.

## Timing
- Reset (rst high at an edge):
  - State goes to IDLE.
  - busy, done, quot, rem, ovf and dbz all go to 0.
  - Internal registers are cleared.
- Latency: start is sampled at edge E. busy is high from E+1 through E+W (W cycles). done is high for exactly one cycle, from E+W+1. Results and flags change only at E+W+1.
- Throughput: one operation per W+1 cycles when start is held or re-asserted during DONE.
- Reset mid-CALC aborts the operation: no done pulse, outputs return to 0, and the next start behaves as from power-up.
- start and rst high at the same edge: reset wins and start is dropped.
- done and busy are never high in the same cycle.

## Configuration
- Macro DIV_SATURATE_EN.
- Defined:
  - Overflow gives quot = 2^(W-1)-1 (127), rem = 0, ovf = 1.
  - Divide by zero gives quot = 127 when a ≥ 0 and -128 when a < 0, rem = 0, dbz = 1.
- Undefined: wrap/all-ones behaviour as specified in Operation.
- Normal results, flags and timing are identical in both builds.

## Test plan
- Signed cases:
  - a = -30, b = 2 → quot = -15, rem = 0, ovf = 0, dbz = 0; done exactly 9 edges after start, busy high for 8 cycles.
  - a = 7, b = -2 → quot = -3, rem = 1.
  - a = -7, b = 2 → quot = -3, rem = -1.
  - a = -5, b = -3 → quot = 1, rem = -2.
- Overflow: a = -128, b = -1 → ovf = 1, rem = 0; quot = -128 without the macro, 127 with DIV_SATURATE_EN.
- Divide by zero: a = 100, b = 0 → dbz = 1; quot = -1, rem = 100 without the macro; quot = 127, rem = 0 with it. Also check a = -100, b = 0 with the macro → quot = -128.
- Handshake:
  - Hold start high with a = 100, b = 7 → quot = 14, rem = 2.
  - Change a and b during CALC → the next result still uses the first operands.
  - Re-assert start in the DONE cycle with a = -128, b = 2 → second done 9 cycles later with quot = -64.
- Reset: assert rst at the 4th CALC cycle of a = 40, b = 3 → no done, all outputs 0. A new start with a = 40, b = -3 → quot = -13, rem = 1.
